// File: rtl/mem_access_unit_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// mem_access_pkg : access-size codes, FSM states and lane helpers for the
//                  MEM-stage data-memory port.
// Revision: 1.0
// ----------------------------------------------------------------------------
package mem_access_pkg;

  localparam logic [1:0] ACCESS_BYTE = 2'd0;
  localparam logic [1:0] ACCESS_HALF = 2'd1;
  localparam logic [1:0] ACCESS_WORD = 2'd2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUSY  = 2'd1,
    DONE  = 2'd2,
    ERROR = 2'd3
  } state_t;

  // Size code 3 falls into the word branches everywhere.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] offset);
    case (size)
      ACCESS_BYTE: is_misaligned = 1'b0;
      ACCESS_HALF: is_misaligned = offset[0];
      default:     is_misaligned = (offset != 2'b00);
    endcase
  endfunction

  function automatic logic [3:0] lane_enable(input logic [1:0] size, input logic [1:0] offset);
    case (size)
      ACCESS_BYTE: lane_enable = 4'b0001 << offset;
      ACCESS_HALF: lane_enable = offset[1] ? 4'b1100 : 4'b0011;
      default:     lane_enable = 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] lane_data(input logic [1:0] size, input logic [31:0] data);
    case (size)
      ACCESS_BYTE: lane_data = {4{data[7:0]}};
      ACCESS_HALF: lane_data = {2{data[15:0]}};
      default:     lane_data = data;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/mem_access_unit_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// mem_access_unit_if : dmem request/ready bus between the MEM stage and memory.
// Revision: 1.0
// ----------------------------------------------------------------------------
interface mem_access_unit_if;

  logic        dmem_request;
  logic        dmem_write;
  logic [31:0] dmem_address;
  logic [3:0]  dmem_byteEnable;
  logic [31:0] dmem_writeData;
  logic        dmem_ready;
  logic [31:0] dmem_readData;

  modport master (
    output dmem_request, dmem_write, dmem_address, dmem_byteEnable, dmem_writeData,
    input  dmem_ready, dmem_readData
  );

  modport slave (
    input  dmem_request, dmem_write, dmem_address, dmem_byteEnable, dmem_writeData,
    output dmem_ready, dmem_readData
  );

endinterface
`default_nettype wire

// File: rtl/mem_access_unit_load_aligner.sv
`default_nettype none
// ----------------------------------------------------------------------------
// mem_load_aligner : selects the addressed lane of a read word and extends it.
// Revision: 1.0
// ----------------------------------------------------------------------------
module mem_load_aligner
  import mem_access_pkg::*;
(
  input  logic [31:0] read_data,
  input  logic [1:0]  offset,
  input  logic [1:0]  size,
  input  logic        sign_extend,
  output logic [31:0] result
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  assign w_byte = 8'(read_data >> {offset, 3'b000});
  assign w_half = 16'(read_data >> {offset[1], 4'b0000});

  always_comb begin
    result = read_data;
    case (size)
      ACCESS_BYTE: result = {{24{sign_extend & w_byte[7]}}, w_byte};
      ACCESS_HALF: result = {{16{sign_extend & w_half[15]}}, w_half};
      default:     result = read_data;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/mem_access_unit.sv
`default_nettype none
// ----------------------------------------------------------------------------
// mem_access_unit : MEM-stage load/store port; stalls the pipeline for each
//                   dmem transaction and flags misaligned or timed-out accesses.
// Revision: 1.0
// ----------------------------------------------------------------------------
module mem_access_unit
  import mem_access_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int TIMEOUT_WIDTH  = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              mem_shouldReadMemory,
  input  logic              mem_shouldWriteMemory,
  input  logic [1:0]        mem_accessSize,
  input  logic              mem_signExtendLoad,
  input  logic [31:0]       mem_aluOutput,
  input  logic [31:0]       mem_storeData,
  input  logic              mem_shouldWriteRegister,
  output logic              mem_stall,
  output logic [31:0]       mem_memoryData,
  output logic              mem_gatedWriteRegister,
  output logic              mem_accessError,
  mem_access_unit_if.master dmem
);

  localparam logic [TIMEOUT_WIDTH-1:0] c_last = TIMEOUT_WIDTH'(TIMEOUT_CYCLES - 1);

  state_t                   r_state;
  state_t                   w_next_state;
  logic [TIMEOUT_WIDTH-1:0] r_count;
  logic [31:0]              r_hold_data;
  logic                     r_request;
  logic                     r_write;
  logic [31:0]              r_address;
  logic [3:0]               r_byte_enable;
  logic [31:0]              r_write_data;

  logic                     w_access;
  logic                     w_misaligned;
  logic                     w_stall;
  logic                     w_error;
  logic [31:0]              w_memory_data;
  logic [31:0]              w_load_result;

  assign w_access     = mem_shouldReadMemory | mem_shouldWriteMemory;
  assign w_misaligned = is_misaligned(mem_accessSize, mem_aluOutput[1:0]);

  // EX/MEM is frozen while BUSY, so the live address/size still describe the access.
  mem_load_aligner u_load_aligner (
    .read_data   (dmem.dmem_readData),
    .offset      (mem_aluOutput[1:0]),
    .size        (mem_accessSize),
    .sign_extend (mem_signExtendLoad),
    .result      (w_load_result)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state  = r_state;
    w_stall       = 1'b0;
    w_error       = 1'b0;
    w_memory_data = 32'h0;
    case (r_state)
      IDLE: begin
        if (w_access) begin
          if (w_misaligned) begin
            w_error = 1'b1;
          end else begin
            w_stall      = 1'b1;
            w_next_state = BUSY;
          end
        end
      end
      BUSY: begin
        w_stall = 1'b1;
        if (dmem.dmem_ready) begin
          w_next_state = DONE;
        end else if (r_count == c_last) begin
          w_next_state = ERROR;
        end
      end
      DONE: begin
        w_memory_data = r_hold_data;
        w_next_state  = IDLE;
      end
      ERROR: begin
        w_error      = 1'b1;
        w_next_state = IDLE;
      end
      default: w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_count       <= '0;
      r_hold_data   <= 32'h0;
      r_request     <= 1'b0;
      r_write       <= 1'b0;
      r_address     <= 32'h0;
      r_byte_enable <= 4'h0;
      r_write_data  <= 32'h0;
    end else begin
      case (r_state)
        IDLE: begin
          r_count <= '0;
          if (w_access && !w_misaligned) begin
            r_request     <= 1'b1;
            r_write       <= mem_shouldWriteMemory;
            r_address     <= {mem_aluOutput[31:2], 2'b00};
            r_byte_enable <= lane_enable(mem_accessSize, mem_aluOutput[1:0]);
            r_write_data  <= mem_shouldWriteMemory ?
                             lane_data(mem_accessSize, mem_storeData) : 32'h0;
          end
        end
        BUSY: begin
          r_count <= r_count + 1'b1;
          if (dmem.dmem_ready) begin
            r_request   <= 1'b0;
            r_hold_data <= r_write ? 32'h0 : w_load_result;
          end else if (r_count == c_last) begin
            r_request <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign dmem.dmem_request    = r_request;
  assign dmem.dmem_write      = r_write;
  assign dmem.dmem_address    = r_address;
  assign dmem.dmem_byteEnable = r_byte_enable;
  assign dmem.dmem_writeData  = r_write_data;

  // Qualified with reset so a held request cannot re-raise stall while in reset.
  assign mem_stall              = w_stall & reset;
  assign mem_accessError        = w_error & reset;
  assign mem_memoryData         = w_memory_data;
  assign mem_gatedWriteRegister = mem_shouldWriteRegister & reset & ~mem_accessError;

endmodule
`default_nettype wire

// File: tb/tb_mem_access_unit.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_mem_access_unit : scoreboard bench for the MEM-stage data-memory port.
// Revision: 1.0
// ----------------------------------------------------------------------------
module tb_mem_access_unit;
  import mem_access_pkg::*;

  logic        clock = 1'b0;
  logic        reset;
  logic        rd_i, wr_i, sext_i, wreg_i;
  logic [1:0]  size_i;
  logic [31:0] addr_i, sd_i;
  logic        stall, gwr, err;
  logic [31:0] mdata;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_q[$];

  int          stall_cyc, busy_cyc;
  logic        finished, end_err, end_gwr, b_write;
  logic [31:0] end_data, b_addr, b_wdata;
  logic [3:0]  b_be;

  always #5 clock = ~clock;

  mem_access_unit_if dmem_bus();

  mem_access_unit #(.TIMEOUT_CYCLES(4), .TIMEOUT_WIDTH(8)) dut (
    .clock                   (clock),
    .reset                   (reset),
    .mem_shouldReadMemory    (rd_i),
    .mem_shouldWriteMemory   (wr_i),
    .mem_accessSize          (size_i),
    .mem_signExtendLoad      (sext_i),
    .mem_aluOutput           (addr_i),
    .mem_storeData           (sd_i),
    .mem_shouldWriteRegister (wreg_i),
    .mem_stall               (stall),
    .mem_memoryData          (mdata),
    .mem_gatedWriteRegister  (gwr),
    .mem_accessError         (err),
    .dmem                    (dmem_bus)
  );

  task automatic drive(input logic r, input logic w, input logic [1:0] sz, input logic se,
                       input logic [31:0] a, input logic [31:0] sd, input logic wr);
    rd_i = r; wr_i = w; size_i = sz; sext_i = se; addr_i = a; sd_i = sd; wreg_i = wr;
  endtask

  task automatic idle_inputs();
    drive(1'b0, 1'b0, 2'd0, 1'b0, 32'h0, 32'h0, 1'b0);
  endtask

  // Acts as the memory: raises ready in BUSY cycle number ready_delay (0 = never),
  // then reports the first non-stalled cycle after the stall.
  task automatic run_access(input int ready_delay, input logic [31:0] rdata);
    logic was_stalled;
    was_stalled = 1'b0;
    stall_cyc = 0; busy_cyc = 0; finished = 1'b0;
    end_data = 32'hX; end_err = 1'bX; end_gwr = 1'bX;
    for (int i = 0; i < 40 && !finished; i++) begin
      @(negedge clock);
      if (dmem_bus.dmem_request) begin
        busy_cyc++;
        if (busy_cyc == 1) begin
          b_addr = dmem_bus.dmem_address; b_be = dmem_bus.dmem_byteEnable;
          b_wdata = dmem_bus.dmem_writeData; b_write = dmem_bus.dmem_write;
        end
        if (busy_cyc == ready_delay) begin
          dmem_bus.dmem_ready = 1'b1; dmem_bus.dmem_readData = rdata;
        end
      end
      if (stall) begin
        stall_cyc++; was_stalled = 1'b1;
      end else if (was_stalled) begin
        finished = 1'b1; end_data = mdata; end_err = err; end_gwr = gwr;
      end
      @(posedge clock); #1;
      dmem_bus.dmem_ready = 1'b0;
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    idle_inputs();
    dmem_bus.dmem_ready = 1'b0; dmem_bus.dmem_readData = 32'h0;
    repeat (2) @(negedge clock);
    checks++; if ({dmem_bus.dmem_request, dmem_bus.dmem_write} !== 2'b00) begin errors++; $display("FAIL reset_req_wr got=%b want=00", {dmem_bus.dmem_request, dmem_bus.dmem_write}); end
    checks++; if (dmem_bus.dmem_address !== 32'h0) begin errors++; $display("FAIL reset_addr got=%h want=0", dmem_bus.dmem_address); end
    checks++; if ({dmem_bus.dmem_byteEnable, dmem_bus.dmem_writeData} !== 36'h0) begin errors++; $display("FAIL reset_be_wdata got=%h want=0", {dmem_bus.dmem_byteEnable, dmem_bus.dmem_writeData}); end
    checks++; if ({stall, err, gwr, mdata} !== 35'h0) begin errors++; $display("FAIL reset_mem_out got=%h want=0", {stall, err, gwr, mdata}); end
    drive(1'b1, 1'b0, ACCESS_WORD, 1'b0, 32'h100, 32'h0, 1'b1);
    @(negedge clock);
    checks++; if ({stall, gwr, dmem_bus.dmem_request} !== 3'b000) begin errors++; $display("FAIL reset_held_load got=%b want=000", {stall, gwr, dmem_bus.dmem_request}); end
    idle_inputs();
    @(posedge clock); #1 reset = 1'b1;
    @(negedge clock);
    checks++; if ({stall, err, mdata, dmem_bus.dmem_request} !== 35'h0) begin errors++; $display("FAIL reset_release_idle got=%h want=0", {stall, err, mdata, dmem_bus.dmem_request}); end
    @(posedge clock); #1;
  endtask

  task automatic test_load_word();
    logic [31:0] exp;
    drive(1'b1, 1'b0, ACCESS_WORD, 1'b0, 32'h100, 32'h0, 1'b1);
    exp_q.push_back(32'hDEADBEEF);
    run_access(3, 32'hDEADBEEF);
    idle_inputs();
    exp = exp_q.pop_front();
    checks++; if (finished !== 1'b1) begin errors++; $display("FAIL lw_finished got=%b want=1", finished); end
    checks++; if (stall_cyc != 4) begin errors++; $display("FAIL lw_stall_cycles got=%0d want=4", stall_cyc); end
    checks++; if (end_data !== exp) begin errors++; $display("FAIL lw_data got=%h want=%h", end_data, exp); end
    checks++; if ({b_write, b_be} !== 5'h0F) begin errors++; $display("FAIL lw_wr_be got=%h want=0f", {b_write, b_be}); end
    checks++; if (b_addr !== 32'h100) begin errors++; $display("FAIL lw_addr got=%h want=00000100", b_addr); end
    checks++; if ({end_err, end_gwr} !== 2'b01) begin errors++; $display("FAIL lw_err_gwr got=%b want=01", {end_err, end_gwr}); end
  endtask

  task automatic test_load_extend();
    logic [31:0] addrs [4] = '{32'h203, 32'h203, 32'h202, 32'h201};
    logic [1:0]  sizes [4] = '{ACCESS_BYTE, ACCESS_BYTE, ACCESS_HALF, ACCESS_BYTE};
    logic        sexts [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    logic [31:0] rds   [4] = '{32'h80000000, 32'h80000000, 32'h80011234, 32'h0000A500};
    logic [31:0] exps  [4] = '{32'hFFFFFF80, 32'h00000080, 32'hFFFF8001, 32'h000000A5};
    logic [31:0] exp;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'b0, sizes[i], sexts[i], addrs[i], 32'h0, 1'b1);
      exp_q.push_back(exps[i]);
      run_access(1, rds[i]);
      idle_inputs();
      exp = exp_q.pop_front();
      checks++; if (stall_cyc != 2 || finished !== 1'b1) begin errors++; $display("FAIL ext%0d_latency got=%0d want=2", i, stall_cyc); end
      checks++; if (end_data !== exp) begin errors++; $display("FAIL ext%0d_data got=%h want=%h", i, end_data, exp); end
    end
  endtask

  task automatic test_store();
    logic [31:0] addrs [3] = '{32'h102, 32'h301, 32'h400};
    logic [1:0]  sizes [3] = '{ACCESS_HALF, ACCESS_BYTE, ACCESS_WORD};
    logic [31:0] sds   [3] = '{32'h1234ABCD, 32'h00000077, 32'hA5A55A5A};
    logic [3:0]  bes   [3] = '{4'b1100, 4'b0010, 4'b1111};
    logic [31:0] wds   [3] = '{32'hABCDABCD, 32'h77777777, 32'hA5A55A5A};
    logic [31:0] was   [3] = '{32'h100, 32'h300, 32'h400};
    logic [31:0] exp;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b1, sizes[i], 1'b0, addrs[i], sds[i], 1'b0);
      exp_q.push_back(32'h0);
      run_access(2, 32'hFFFFFFFF);
      idle_inputs();
      exp = exp_q.pop_front();
      checks++; if ({b_write, b_be} !== {1'b1, bes[i]}) begin errors++; $display("FAIL st%0d_wr_be got=%h want=%h", i, {b_write, b_be}, {1'b1, bes[i]}); end
      checks++; if (b_wdata !== wds[i]) begin errors++; $display("FAIL st%0d_wdata got=%h want=%h", i, b_wdata, wds[i]); end
      checks++; if (b_addr !== was[i]) begin errors++; $display("FAIL st%0d_addr got=%h want=%h", i, b_addr, was[i]); end
      checks++; if (end_data !== exp || finished !== 1'b1) begin errors++; $display("FAIL st%0d_done_data got=%h want=%h", i, end_data, exp); end
    end
  endtask

  task automatic test_misaligned();
    logic [31:0] addrs [2] = '{32'h101, 32'h201};
    logic [1:0]  sizes [2] = '{ACCESS_WORD, ACCESS_HALF};
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, i[0], sizes[i], 1'b0, addrs[i], 32'h0, 1'b1);
      @(negedge clock);
      checks++; if ({err, stall, gwr} !== 3'b100) begin errors++; $display("FAIL mis%0d_flags got=%b want=100", i, {err, stall, gwr}); end
      checks++; if (mdata !== 32'h0) begin errors++; $display("FAIL mis%0d_data got=%h want=0", i, mdata); end
      @(posedge clock); #1;
      idle_inputs();
      @(negedge clock);
      checks++; if ({err, dmem_bus.dmem_request} !== 2'b00) begin errors++; $display("FAIL mis%0d_after got=%b want=00", i, {err, dmem_bus.dmem_request}); end
      @(posedge clock); #1;
    end
  endtask

  task automatic test_timeout();
    logic [31:0] exp;
    drive(1'b1, 1'b0, ACCESS_WORD, 1'b0, 32'h700, 32'h0, 1'b1);
    exp_q.push_back(32'h0);
    run_access(0, 32'h0);
    idle_inputs();
    exp = exp_q.pop_front();
    checks++; if (finished !== 1'b1 || busy_cyc != 4) begin errors++; $display("FAIL to_busy_cycles got=%0d want=4", busy_cyc); end
    checks++; if ({end_err, end_gwr} !== 2'b10) begin errors++; $display("FAIL to_err_gwr got=%b want=10", {end_err, end_gwr}); end
    checks++; if (end_data !== exp) begin errors++; $display("FAIL to_data got=%h want=%h", end_data, exp); end
    @(negedge clock);
    checks++; if ({err, stall, dmem_bus.dmem_request} !== 3'b000) begin errors++; $display("FAIL to_idle got=%b want=000", {err, stall, dmem_bus.dmem_request}); end
    @(posedge clock); #1;
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp;
    exp_q.push_back(32'h11223344);
    exp_q.push_back(32'h0000CAFE);
    drive(1'b1, 1'b0, ACCESS_WORD, 1'b0, 32'h600, 32'h0, 1'b1);
    run_access(1, 32'h11223344);
    exp = exp_q.pop_front();
    checks++; if (end_data !== exp) begin errors++; $display("FAIL b2b_first got=%h want=%h", end_data, exp); end
    drive(1'b1, 1'b0, ACCESS_HALF, 1'b0, 32'h602, 32'h0, 1'b1);
    run_access(2, 32'hCAFE0000);
    idle_inputs();
    exp = exp_q.pop_front();
    checks++; if (end_data !== exp) begin errors++; $display("FAIL b2b_second got=%h want=%h", end_data, exp); end
    checks++; if (stall_cyc != 3) begin errors++; $display("FAIL b2b_second_stall got=%0d want=3", stall_cyc); end
  endtask

  task automatic test_stray_ready();
    dmem_bus.dmem_ready = 1'b1; dmem_bus.dmem_readData = 32'hFFFFFFFF;
    for (int i = 0; i < 2; i++) begin
      @(negedge clock);
      checks++; if ({stall, err, dmem_bus.dmem_request, mdata} !== 35'h0) begin errors++; $display("FAIL stray%0d got=%h want=0", i, {stall, err, dmem_bus.dmem_request, mdata}); end
    end
    @(posedge clock); #1 dmem_bus.dmem_ready = 1'b0;
  endtask

  task automatic test_reset_mid_busy();
    drive(1'b1, 1'b0, ACCESS_WORD, 1'b0, 32'h500, 32'h0, 1'b1);
    repeat (3) @(negedge clock);
    checks++; if ({dmem_bus.dmem_request, stall} !== 2'b11) begin errors++; $display("FAIL rmb_busy got=%b want=11", {dmem_bus.dmem_request, stall}); end
    reset = 1'b0;
    #1;
    checks++; if ({dmem_bus.dmem_request, stall} !== 2'b00) begin errors++; $display("FAIL rmb_drop got=%b want=00", {dmem_bus.dmem_request, stall}); end
    idle_inputs();
    @(posedge clock); #1 reset = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clock);
      checks++; if ({stall, err, gwr, mdata, dmem_bus.dmem_request} !== 36'h0) begin errors++; $display("FAIL rmb_idle%0d got=%h want=0", i, {stall, err, gwr, mdata, dmem_bus.dmem_request}); end
    end
    @(posedge clock); #1;
  endtask

  initial begin
    test_reset();
    test_load_word();
    test_load_extend();
    test_store();
    test_misaligned();
    test_timeout();
    test_back_to_back();
    test_stray_ready();
    test_reset_mid_busy();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1);
  end

endmodule
`default_nettype wire
